axis_job_streamer: RTL

- AXI-Stream counterpart of the miner stream wrapper.
- Takes a parallel job of NUMBER_OF_JOB_WORDS words (block header plus nonce range), streams it to the miner as an AXI-Stream master, then accepts the NUMBER_OF_RESULT_WORDS result stream as an AXI-Stream slave.
- Presents the captured result in parallel with a done pulse.
- Used as the on-chip job driver and as a loopback bench source for the miner IP.

---
 rtl/axis_job_streamer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axis_job_streamer.sv
// axis_job_streamer: snapshots a parallel job, streams it out as an AXI-Stream master,
// then collects a fixed-length result stream as a slave and presents it in parallel.
module axis_job_streamer #(
  parameter int C_AXIS_TDATA_WIDTH     = 32,
  parameter int NUMBER_OF_JOB_WORDS    = 20,
  parameter int NUMBER_OF_RESULT_WORDS = 8
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [NUMBER_OF_JOB_WORDS*C_AXIS_TDATA_WIDTH-1:0]    job_in,
  output logic                                                 busy,
  output logic                                                 done,
  output logic [NUMBER_OF_RESULT_WORDS*C_AXIS_TDATA_WIDTH-1:0] result_out,
  output logic                                                 result_valid,
  output logic                                                 error,
  output logic                                                 m_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                        m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]                      m_axis_tstrb,
  output logic                                                 m_axis_tlast,
  input  logic                                                 m_axis_tready,
  output logic                                                 s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]                        s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]                      s_axis_tstrb,
  input  logic                                                 s_axis_tlast,
  input  logic                                                 s_axis_tvalid
);

  localparam int W        = C_AXIS_TDATA_WIDTH;
  localparam int TX_PTR_W = (NUMBER_OF_JOB_WORDS > 1) ? $clog2(NUMBER_OF_JOB_WORDS) : 1;
  localparam int RX_PTR_W = (NUMBER_OF_RESULT_WORDS > 1) ? $clog2(NUMBER_OF_RESULT_WORDS) : 1;
  localparam logic [TX_PTR_W-1:0] TX_LAST = TX_PTR_W'(NUMBER_OF_JOB_WORDS - 1);
  localparam logic [RX_PTR_W-1:0] RX_LAST = RX_PTR_W'(NUMBER_OF_RESULT_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_RECV   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [TX_PTR_W-1:0]   tx_ptr_r;
  logic [RX_PTR_W-1:0]   rx_ptr_r;
  logic [W-1:0]          job_buf_r [NUMBER_OF_JOB_WORDS];
  logic [W-1:0]          result_r  [NUMBER_OF_RESULT_WORDS];
  logic                  busy_r, done_r, result_valid_r, error_r;
  logic                  m_tvalid_r, s_tready_r;
  logic                  accept_s, tx_hs_s, tx_last_s, rx_hs_s, rx_last_s, rx_end_s, rx_err_s;
  logic                  strb_unused_s;

  assign strb_unused_s = ^s_axis_tstrb;
  assign tx_last_s     = (tx_ptr_r == TX_LAST);
  assign rx_last_s     = (rx_ptr_r == RX_LAST);

  // Next-state decode and handshake strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    tx_hs_s  = 1'b0;
    rx_hs_s  = 1'b0;
    rx_end_s = 1'b0;
    rx_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = ST_SEND;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (m_tvalid_r && m_axis_tready) begin
          tx_hs_s = 1'b1;
          state_s = tx_last_s ? ST_RECV : ST_SEND;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_RECV: begin
        if (s_tready_r && s_axis_tvalid) begin
          rx_hs_s = 1'b1;
          // A result ends on the expected count or on an early tlast, whichever comes first
          rx_end_s = rx_last_s || s_axis_tlast;
          rx_err_s = !(rx_last_s && s_axis_tlast);
          state_s  = rx_end_s ? ST_FINISH : ST_RECV;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register and state-decoded outputs, registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      m_tvalid_r <= 1'b0;
      s_tready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_FINISH);
      m_tvalid_r <= (state_s == ST_SEND);
      s_tready_r <= (state_s == ST_RECV);
    end
  end

  // Job snapshot, pointers, result capture and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ptr_r       <= '0;
      rx_ptr_r       <= '0;
      result_valid_r <= 1'b0;
      error_r        <= 1'b0;
      for (int k = 0; k < NUMBER_OF_JOB_WORDS; k++) job_buf_r[k] <= '0;
      for (int k = 0; k < NUMBER_OF_RESULT_WORDS; k++) result_r[k] <= '0;
    end else begin
      if (accept_s) begin
        tx_ptr_r       <= '0;
        result_valid_r <= 1'b0;
        error_r        <= 1'b0;
        for (int k = 0; k < NUMBER_OF_JOB_WORDS; k++) job_buf_r[k] <= job_in[k*W +: W];
        // Stale words from the previous result must not survive a short result
        for (int k = 0; k < NUMBER_OF_RESULT_WORDS; k++) result_r[k] <= '0;
      end
      if (tx_hs_s) begin
        if (tx_last_s) begin
          tx_ptr_r <= '0;
          rx_ptr_r <= '0;
        end else begin
          tx_ptr_r <= tx_ptr_r + TX_PTR_W'(1);
        end
      end
      if (rx_hs_s) begin
        result_r[rx_ptr_r] <= s_axis_tdata;
        if (rx_end_s) begin
          error_r        <= rx_err_s;
          result_valid_r <= 1'b1;
        end else begin
          rx_ptr_r <= rx_ptr_r + RX_PTR_W'(1);
        end
      end
    end
  end

  // Pack the captured result words onto the parallel output
  always_comb begin
    result_out = '0;
    for (int k = 0; k < NUMBER_OF_RESULT_WORDS; k++) result_out[k*W +: W] = result_r[k];
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign result_valid  = result_valid_r;
  assign error         = error_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tdata  = job_buf_r[tx_ptr_r];
  assign m_axis_tlast  = m_tvalid_r && tx_last_s;
  assign m_axis_tstrb  = {(C_AXIS_TDATA_WIDTH/8){1'b1}};
  assign s_axis_tready = s_tready_r;

endmodule
